// File: rtl/o_spike_tx.sv
// o_spike_tx: gathers spike indices during a timestep and presents them as one packet on frame_end.
// Define SPIKE_TX_OVF_CNT_EN to add the dropped-spike counter ovf_cnt and the sticky ovf_flag.
module o_spike_tx #(
    parameter int unsigned MAX_SPIKE = 128,
    parameter int unsigned IDX_W     = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spk_valid,
    input  logic [IDX_W-1:0]           spk_index,
    output logic                       spk_ready,
    input  logic                       frame_end,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [7:0]                 spike_num,
    output logic [IDX_W*MAX_SPIKE-1:0] spike_index_flat,
    output logic                       busy
`ifdef SPIKE_TX_OVF_CNT_EN
    ,
    output logic [15:0]                ovf_cnt,
    output logic                       ovf_flag
`endif
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FLAT_W = IDX_W * MAX_SPIKE;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_SEND    = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [FLAT_W-1:0] r_slots;
    logic              w_full;
    logic              w_accept;
    logic              w_handshake;

    assign w_full      = (r_count == CNT_W'(MAX_SPIKE));
    assign w_accept    = (r_state == S_COLLECT) && spk_valid && !w_full;
    assign w_handshake = (r_state == S_SEND) && ready_in;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: frame_end closes the frame, downstream handshake reopens it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (frame_end) w_state_nxt = S_SEND;
            S_SEND:    if (ready_in)  w_state_nxt = S_COLLECT;
        endcase
    end

    // Slot buffer and fill count; a spike accepted alongside frame_end still lands in the packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_slots <= '0;
        end else if (w_handshake) begin
            r_count <= '0;
            r_slots <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
            for (int unsigned i = 0; i < MAX_SPIKE; i++) begin
                if (r_count == CNT_W'(i)) begin
                    r_slots[i*IDX_W +: IDX_W] <= spk_index;
                end
            end
        end
    end

`ifdef SPIKE_TX_OVF_CNT_EN
    logic        w_drop;
    logic [15:0] r_ovf_cnt;
    logic        r_ovf_flag;

    assign w_drop = (r_state == S_COLLECT) && spk_valid && w_full;

    // Saturating drop counter with sticky flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_cnt  <= '0;
            r_ovf_flag <= 1'b0;
        end else if (w_drop) begin
            r_ovf_flag <= 1'b1;
            if (r_ovf_cnt != 16'hFFFF) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign ovf_cnt  = r_ovf_cnt;
    assign ovf_flag = r_ovf_flag;
`endif

    assign spk_ready        = (r_state == S_COLLECT);
    assign valid_out        = (r_state == S_SEND);
    assign busy             = (r_state == S_SEND);
    assign spike_num        = r_count;
    assign spike_index_flat = r_slots;

endmodule

// File: tb/tb_o_spike_tx.sv
// Self-checking bench for o_spike_tx: directed scenarios plus randomized traffic against a queue model.
module tb_o_spike_tx;
    localparam int unsigned MAX_SPIKE = 128;
    localparam int unsigned IDX_W     = 14;
    localparam int unsigned FLAT_W    = MAX_SPIKE * IDX_W;

    logic              clk;
    logic              rst_n;
    logic              spk_valid;
    logic [IDX_W-1:0]  spk_index;
    logic              spk_ready;
    logic              frame_end;
    logic              valid_out;
    logic              ready_in;
    logic [7:0]        spike_num;
    logic [FLAT_W-1:0] spike_index_flat;
    logic              busy;
`ifdef SPIKE_TX_OVF_CNT_EN
    logic [15:0]       ovf_cnt;
    logic              ovf_flag;
`endif

    int n_checks;
    int n_fail;
    logic [IDX_W-1:0] m_q[$];
    int m_drops;

    o_spike_tx #(.MAX_SPIKE(MAX_SPIKE), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .spk_valid        (spk_valid),
        .spk_index        (spk_index),
        .spk_ready        (spk_ready),
        .frame_end        (frame_end),
        .valid_out        (valid_out),
        .ready_in         (ready_in),
        .spike_num        (spike_num),
        .spike_index_flat (spike_index_flat),
        .busy             (busy)
`ifdef SPIKE_TX_OVF_CNT_EN
        ,
        .ovf_cnt          (ovf_cnt),
        .ovf_flag         (ovf_flag)
`endif
    );

    always #5 clk = ~clk;

    // Expected flat bus: queue entries in order from slot 0, everything above them zero
    function automatic logic [FLAT_W-1:0] pack_q();
        logic [FLAT_W-1:0] f;
        f = '0;
        foreach (m_q[i]) f = f | (FLAT_W'(m_q[i]) << (i * IDX_W));
        return f;
    endfunction

    function automatic int first_diff(input logic [FLAT_W-1:0] a, input logic [FLAT_W-1:0] b);
        for (int s = 0; s < int'(MAX_SPIKE); s++)
            if (IDX_W'(a >> (s * IDX_W)) !== IDX_W'(b >> (s * IDX_W))) return s;
        return -1;
    endfunction

    function automatic logic [IDX_W-1:0] slot_of(input logic [FLAT_W-1:0] a, input int s);
        return IDX_W'(a >> (s * IDX_W));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        spk_valid = 1'b0;
        spk_index = '0;
        frame_end = 1'b0;
        ready_in  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_q.delete();
        m_drops = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({valid_out, busy, spk_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/busy/ready got %b exp 001", {valid_out, busy, spk_ready});
        end
        n_checks++;
        if (spike_num !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_num: got %0d exp 0", spike_num);
        end
        n_checks++;
        if (spike_index_flat !== '0) begin
            n_fail++;
            $display("FAIL reset_flat: slot %0d nonzero", first_diff(spike_index_flat, '0));
        end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [FLAT_W-1:0] exp_flat;
        apply_reset();
        ready_in  = 1'b1;
        spk_valid = 1'b1;
        spk_index = IDX_W'(5);
        tick();
        n_checks++;
        if ({valid_out, spk_ready, spike_num} !== {1'b0, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL basic_first: valid=%b ready=%b num=%0d exp 0 1 1", valid_out, spk_ready, spike_num);
        end
        spk_index = IDX_W'(9);
        tick();
        spk_index = IDX_W'(42);
        frame_end = 1'b1;
        tick();
        spk_valid = 1'b0;
        frame_end = 1'b0;
        m_q = '{IDX_W'(5), IDX_W'(9), IDX_W'(42)};
        exp_flat = pack_q();
        n_checks++;
        if ({valid_out, busy, spk_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_valid: valid/busy/ready got %b exp 110", {valid_out, busy, spk_ready});
        end
        n_checks++;
        if (spike_num !== 8'd3) begin
            n_fail++;
            $display("FAIL basic_num: got %0d exp 3", spike_num);
        end
        n_checks++;
        if (spike_index_flat !== exp_flat) begin
            n_fail++;
            $display("FAIL basic_flat: slot %0d got %0d exp %0d", first_diff(spike_index_flat, exp_flat),
                     slot_of(spike_index_flat, first_diff(spike_index_flat, exp_flat)),
                     slot_of(exp_flat, first_diff(spike_index_flat, exp_flat)));
        end
        tick();
        m_q.delete();
        n_checks++;
        if ({valid_out, spk_ready, spike_num} !== {1'b0, 1'b1, 8'd0} || spike_index_flat !== '0) begin
            n_fail++;
            $display("FAIL basic_after_hs: valid=%b ready=%b num=%0d exp 0 1 0 with empty slots",
                     valid_out, spk_ready, spike_num);
        end
        idle_inputs();
    endtask

    task automatic test_empty();
        apply_reset();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        n_checks++;
        if ({valid_out, spike_num} !== {1'b1, 8'd0} || spike_index_flat !== '0) begin
            n_fail++;
            $display("FAIL empty_pkt: valid=%b num=%0d exp 1 0 with empty slots", valid_out, spike_num);
        end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        n_checks++;
        if ({valid_out, spk_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL empty_hs: valid/ready got %b exp 01", {valid_out, spk_ready});
        end
    endtask

    task automatic test_backpressure();
        logic [FLAT_W-1:0] exp_flat;
        int k;
        apply_reset();
        k = int'($urandom_range(1, 20));
        spk_valid = 1'b1;
        for (int i = 0; i < k; i++) begin
            spk_index = IDX_W'($urandom);
            m_q.push_back(spk_index);
            tick();
        end
        spk_valid = 1'b0;
        frame_end = 1'b1;
        tick();
        exp_flat = pack_q();
        for (int c = 0; c < 10; c++) begin
            spk_valid = 1'b1;
            spk_index = IDX_W'($urandom);
            frame_end = (c == 3);
            ready_in  = 1'b0;
            n_checks++;
            if ({valid_out, busy, spk_ready, spike_num} !== {1'b1, 1'b1, 1'b0, 8'(k)}) begin
                n_fail++;
                $display("FAIL bp_hold_ctrl c=%0d: valid=%b busy=%b ready=%b num=%0d exp 1 1 0 %0d",
                         c, valid_out, busy, spk_ready, spike_num, k);
            end
            n_checks++;
            if (spike_index_flat !== exp_flat) begin
                n_fail++;
                $display("FAIL bp_hold_flat c=%0d: slot %0d differs", c, first_diff(spike_index_flat, exp_flat));
            end
            tick();
        end
        idle_inputs();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        m_q.delete();
        n_checks++;
        if ({valid_out, busy, spk_ready, spike_num} !== {1'b0, 1'b0, 1'b1, 8'd0} || spike_index_flat !== '0) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b busy=%b ready=%b num=%0d exp 0 0 1 0",
                     valid_out, busy, spk_ready, spike_num);
        end
    endtask

    task automatic test_overflow();
        logic [FLAT_W-1:0] exp_flat;
        apply_reset();
        spk_valid = 1'b1;
        for (int i = 0; i < 130; i++) begin
            spk_index = IDX_W'(i);
            if (i < int'(MAX_SPIKE)) m_q.push_back(spk_index);
            if (i == 129) begin
                n_checks++;
                if (spk_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_ready_when_full: got %b exp 1", spk_ready);
                end
            end
            tick();
        end
        spk_valid = 1'b0;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        exp_flat = pack_q();
        n_checks++;
        if ({valid_out, spike_num} !== {1'b1, 8'd128}) begin
            n_fail++;
            $display("FAIL ovf_num: valid=%b num=%0d exp 1 128", valid_out, spike_num);
        end
        n_checks++;
        if (spike_index_flat !== exp_flat) begin
            n_fail++;
            $display("FAIL ovf_flat: slot %0d got %0d", first_diff(spike_index_flat, exp_flat),
                     slot_of(spike_index_flat, first_diff(spike_index_flat, exp_flat)));
        end
`ifdef SPIKE_TX_OVF_CNT_EN
        n_checks++;
        if ({ovf_cnt, ovf_flag} !== {16'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_counter: cnt=%0d flag=%b exp 2 1", ovf_cnt, ovf_flag);
        end
`endif
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        m_q.delete();
    endtask

    task automatic test_reset_mid_send();
        logic [FLAT_W-1:0] exp_flat;
        apply_reset();
        spk_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            spk_index = IDX_W'($urandom);
            frame_end = (i == 3);
            tick();
        end
        idle_inputs();
        n_checks++;
        if (valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_send_entry: valid=%b exp 1", valid_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({valid_out, busy, spk_ready, spike_num} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_send_async: valid=%b busy=%b ready=%b num=%0d exp 0 0 1 0",
                     valid_out, busy, spk_ready, spike_num);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_q.delete();
        spk_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            spk_index = IDX_W'($urandom);
            m_q.push_back(spk_index);
            frame_end = (i == 1);
            tick();
        end
        idle_inputs();
        exp_flat = pack_q();
        n_checks++;
        if ({valid_out, spike_num} !== {1'b1, 8'd2} || spike_index_flat !== exp_flat) begin
            n_fail++;
            $display("FAIL rst_send_next_frame: valid=%b num=%0d exp 1 2, first bad slot %0d",
                     valid_out, spike_num, first_diff(spike_index_flat, exp_flat));
        end
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        m_q.delete();
    endtask

    // Randomized traffic: model keeps accepted indices in a queue, packet is the queue while sending
    task automatic test_random();
        bit m_send;
        logic [FLAT_W-1:0] exp_flat;
        apply_reset();
        m_send = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            spk_valid = ($urandom_range(0, 2) != 0);
            spk_index = IDX_W'($urandom);
            frame_end = (c < 700) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 219) == 0);
            ready_in  = ($urandom_range(0, 2) == 0);
            if (!m_send) begin
                if (spk_valid) begin
                    if (m_q.size() < int'(MAX_SPIKE)) m_q.push_back(spk_index);
                    else m_drops++;
                end
                if (frame_end) m_send = 1'b1;
            end else if (ready_in) begin
                m_send = 1'b0;
                m_q.delete();
            end
            tick();
            exp_flat = pack_q();
            n_checks++;
            if ({valid_out, busy, spk_ready, spike_num} !== {m_send, m_send, !m_send, 8'(m_q.size())}) begin
                n_fail++;
                $display("FAIL rand_ctrl c=%0d: valid=%b busy=%b ready=%b num=%0d exp %b %b %b %0d",
                         c, valid_out, busy, spk_ready, spike_num, m_send, m_send, !m_send, m_q.size());
            end
            n_checks++;
            if (spike_index_flat !== exp_flat) begin
                n_fail++;
                $display("FAIL rand_flat c=%0d: slot %0d got %0d exp %0d", c, first_diff(spike_index_flat, exp_flat),
                         slot_of(spike_index_flat, first_diff(spike_index_flat, exp_flat)),
                         slot_of(exp_flat, first_diff(spike_index_flat, exp_flat)));
            end
`ifdef SPIKE_TX_OVF_CNT_EN
            n_checks++;
            if ({ovf_cnt, ovf_flag} !== {16'(m_drops), (m_drops > 0)}) begin
                n_fail++;
                $display("FAIL rand_ovf c=%0d: cnt=%0d flag=%b exp %0d %b", c, ovf_cnt, ovf_flag, m_drops, m_drops > 0);
            end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        m_drops  = 0;
        idle_inputs();
        test_reset();
        test_basic();
        test_empty();
        test_backpressure();
        test_overflow();
        test_reset_mid_send();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/o_spike_tx.md
O_SPIKE_TX -- requirements
Module: o_spike_tx

Interface
REQ-001 Parameter MAX_SPIKE, default 128, max spikes per packet (1..255).
REQ-002 Parameter IDX_W, default 14, spike index width.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 spk_valid  input  1  spike event offered by neuron array.
REQ-006 spk_index  input  IDX_W  index of offered spike.
REQ-007 spk_ready  output  1  event port accepting; high in COLLECT only.
REQ-008 frame_end  input  1  single-cycle timestep-end strobe.
REQ-009 valid_out  output  1  packet valid toward downstream spike receiver.
REQ-010 ready_in  input  1  downstream ready.
REQ-011 spike_num  output  8  spikes in packet.
REQ-012 spike_index_flat  output  IDX_W*MAX_SPIKE  slot i at bits [i*IDX_W +: IDX_W].
REQ-013 busy  output  1  high while in SEND.

Function
REQ-014 FSM has two states: COLLECT (accepting spikes) and SEND (presenting packet).
REQ-015 COLLECT: event accepted when spk_valid && spk_ready && count < MAX_SPIKE; index written to slot[count], count increments by 1.
REQ-016 COLLECT, buffer full (count == MAX_SPIKE): spk_ready stays 1; offered spikes dropped; count and slots unchanged.
REQ-017 frame_end in COLLECT -> SEND next cycle; spike accepted in same cycle as frame_end is included in packet.
REQ-018 Latency: frame_end at edge N -> valid_out = 1, spike_num = final count at edge N+1.
REQ-019 frame_end with count == 0 still produces packet, spike_num = 0, all slots zero.
REQ-020 SEND: valid_out = 1; spike_num and spike_index_flat held stable until handshake.
REQ-021 Handshake = valid_out && ready_in at a rising edge; next cycle: COLLECT, valid_out = 0, count = 0, all slots zeroed, spk_ready = 1.
REQ-022 ready_in asserted before valid_out is ignored; no handshake occurs in COLLECT.
REQ-023 SEND: spk_ready = 0; spk_valid ignored; frame_end ignored (no queuing).
REQ-024 Slots >= spike_num always zero in a presented packet.
REQ-025 spike_num = count, zero-extended to 8 bits.
REQ-026 busy = 1 exactly when state is SEND.

Reset
REQ-027 rst_n low asynchronously forces COLLECT, count = 0, all slots 0, valid_out = 0, spike_num = 0, busy = 0.
REQ-028 During reset spk_ready = 1; reset in SEND discards packet without handshake.
REQ-029 First accept possible at first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro SPIKE_TX_OVF_CNT_EN defined: add output ovf_cnt[15:0], counting spikes dropped per REQ-016, saturating at 16'hFFFF, cleared only by reset; add output ovf_flag, sticky 1 after first drop until reset.
REQ-031 Macro undefined: ovf_cnt and ovf_flag ports absent; drops silent; all other behaviour identical.

Verification
REQ-032 Reset, 3 spikes idx 5,9,42 on consecutive cycles, frame_end with 3rd, ready_in=1 -> valid_out next cycle, spike_num=3, slots 0..2 = 5,9,42, rest 0; one-cycle valid.
REQ-033 frame_end with no spikes -> valid_out=1, spike_num=0, spike_index_flat all zero.
REQ-034 Packet with ready_in=0 for 10 cycles while spk_valid=1, frame_end pulsed -> outputs stable, spk_ready=0, busy=1; ready_in=1 -> COLLECT next cycle, count 0.
REQ-035 130 spikes (idx 0..129) then frame_end, MAX_SPIKE=128 -> spike_num=128, slots hold 0..127; with SPIKE_TX_OVF_CNT_EN ovf_cnt=2, ovf_flag=1.
REQ-036 rst_n low mid-SEND -> valid_out=0, spike_num=0, spk_ready=1 immediately; next frame carries only post-reset spikes.
